// File: rtl/main_vid_port_if.sv
// CPU bus bundle for the video block: request, address, write strobe/data, read hit and data.
// The CPU side drives the request fields; the video block returns VIDDV/VIDRD.
interface main_vid_port_if;
  logic        CPUMX;
  logic [15:0] CPUAD;
  logic        CPUWR;
  logic [7:0]  CPUWD;
  logic        VIDDV;
  logic [7:0]  VIDRD;

  modport master (output CPUMX, CPUAD, CPUWR, CPUWD, input VIDDV, VIDRD);
  modport slave  (input CPUMX, CPUAD, CPUWR, CPUWD, output VIDDV, VIDRD);
endinterface

// File: rtl/main_vid_port.sv
// Video memory port: colour/code/sprite RAMs, per-row scroll table and sprite bank, CPU plus video read ports.
// All read data registered, latency 1 cycle; no backpressure, one write commit per CPU bus cycle.
module main_vid_port (
  input  logic           CPUCL,
  input  logic           RESET,
  main_vid_port_if.slave cpu,
  input  logic [8:0]     PV,
  input  logic [10:0]    VAD,
  output logic [15:0]    VDT,
  input  logic [7:0]     SAD,
  output logic [7:0]     SDT,
  output logic [8:0]     SCRX,
  output logic           SPBNK
);

  logic        sel_col, sel_code, sel_spr, sel_slo, sel_shi, sel_bnk;
  logic        hit, wr_req, commit;
  logic        wq_q, wq_d;
  logic [7:0]  col_mem  [2048];
  logic [7:0]  code_mem [2048];
  logic [7:0]  spr_mem  [4096];
  logic [7:0]  scr_lo_q [32];
  logic [7:0]  scr_lo_d [32];
  logic        scr_hi_q [32];
  logic        scr_hi_d [32];
  logic        spbnk_q, spbnk_d;
  logic [7:0]  rd_q, rd_d;
  logic [15:0] vdt_q, vdt_d;
  logic [7:0]  sdt_q, sdt_d;
  logic [8:0]  scrx_q, scrx_d;
  logic [4:0]  row;
  logic        unused_pv8;

  assign sel_col  = cpu.CPUAD[15:11] == 5'b11000;
  assign sel_code = cpu.CPUAD[15:11] == 5'b11001;
  assign sel_spr  = cpu.CPUAD[15:12] == 4'hD;
  assign sel_slo  = cpu.CPUAD[15:5] == 11'h700;
  assign sel_shi  = cpu.CPUAD[15:5] == 11'h701;
  assign sel_bnk  = cpu.CPUAD == 16'hE043;
  assign hit      = sel_col | sel_code | sel_spr | sel_slo | sel_shi | sel_bnk;

  // Commit only on the rising edge of a qualifying write; held or re-addressed cycles are ignored.
  assign wr_req = cpu.CPUMX & cpu.CPUWR & hit;
  assign commit = wr_req & ~wq_q & ~RESET;

  // Line 256+n aliases row n>>3.
  assign row        = PV[7:3];
  assign unused_pv8 = PV[8];

  always_ff @(posedge CPUCL) begin
    if (commit && sel_col)  col_mem[cpu.CPUAD[10:0]]  <= cpu.CPUWD;
    if (commit && sel_code) code_mem[cpu.CPUAD[10:0]] <= cpu.CPUWD;
    if (commit && sel_spr)  spr_mem[cpu.CPUAD[11:0]]  <= cpu.CPUWD;
  end

  always_comb begin
    wq_d     = wr_req;
    scr_lo_d = scr_lo_q;
    scr_hi_d = scr_hi_q;
    spbnk_d  = spbnk_q;
    if (commit) begin
      if (sel_slo) scr_lo_d[cpu.CPUAD[4:0]] = cpu.CPUWD;
      if (sel_shi) scr_hi_d[cpu.CPUAD[4:0]] = cpu.CPUWD[0];
      if (sel_bnk) spbnk_d = cpu.CPUWD[3];
    end
  end

  always_comb begin
    rd_d = 8'h00;
    if (sel_col)       rd_d = col_mem[cpu.CPUAD[10:0]];
    else if (sel_code) rd_d = code_mem[cpu.CPUAD[10:0]];
    else if (sel_spr)  rd_d = spr_mem[cpu.CPUAD[11:0]];
    else if (sel_slo)  rd_d = scr_lo_q[cpu.CPUAD[4:0]];
    else if (sel_shi)  rd_d = {7'b0, scr_hi_q[cpu.CPUAD[4:0]]};
    else if (sel_bnk)  rd_d = {4'b0, spbnk_q, 3'b0};
  end

  // Video reads sample the arrays before the same-edge write lands, giving old data.
  always_comb begin
    vdt_d  = {col_mem[VAD], code_mem[VAD]};
    sdt_d  = spr_mem[{3'b000, spbnk_q, SAD}];
    scrx_d = {scr_hi_q[row], scr_lo_q[row]};
  end

  always_ff @(posedge CPUCL or posedge RESET) begin
    if (RESET) begin
      wq_q     <= 1'b0;
      scr_lo_q <= '{default: 8'h00};
      scr_hi_q <= '{default: 1'b0};
      spbnk_q  <= 1'b0;
      rd_q     <= 8'h00;
      vdt_q    <= 16'h0000;
      sdt_q    <= 8'h00;
      scrx_q   <= 9'h000;
    end else begin
      wq_q     <= wq_d;
      scr_lo_q <= scr_lo_d;
      scr_hi_q <= scr_hi_d;
      spbnk_q  <= spbnk_d;
      rd_q     <= rd_d;
      vdt_q    <= vdt_d;
      sdt_q    <= sdt_d;
      scrx_q   <= scrx_d;
    end
  end

  assign cpu.VIDDV = cpu.CPUMX & ~cpu.CPUWR & hit;
  assign cpu.VIDRD = rd_q;
  assign VDT       = vdt_q;
  assign SDT       = sdt_q;
  assign SCRX      = scrx_q;
  assign SPBNK     = spbnk_q;

endmodule

// File: tb/tb_main_vid_port.sv
// Randomised bench for main_vid_port against a flat address-map model of the video memory.
module tb_main_vid_port;
  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  pv;
  logic [10:0] vad;
  logic [7:0]  sad;
  logic [15:0] vdt;
  logic [7:0]  sdt;
  logic [8:0]  scrx;
  logic        spbnk;

  main_vid_port_if bus();

  main_vid_port dut (
    .CPUCL (clk),
    .RESET (rst),
    .cpu   (bus),
    .PV    (pv),
    .VAD   (vad),
    .VDT   (vdt),
    .SAD   (sad),
    .SDT   (sdt),
    .SCRX  (scrx),
    .SPBNK (spbnk)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] mem [int];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    if ($isunknown(exp)) return;
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] region_mask(input int a);
    if (a >= 'hC000 && a <= 'hDFFF) return 8'hFF;
    if (a >= 'hE000 && a <= 'hE01F) return 8'hFF;
    if (a >= 'hE020 && a <= 'hE03F) return 8'h01;
    if (a == 'hE043)                return 8'h08;
    return 8'h00;
  endfunction

  function automatic bit is_hit(input int a);
    return region_mask(a) != 8'h00;
  endfunction

  function automatic logic [7:0] mrd(input int a);
    if (mem.exists(a)) return mem[a];
    return 8'hxx;
  endfunction

  function automatic logic bank();
    logic [7:0] b;
    b = mrd('hE043);
    return b[3];
  endfunction

  function automatic logic [15:0] exp_vdt(input logic [10:0] va);
    return {mrd('hC000 + int'(va)), mrd('hC800 + int'(va))};
  endfunction

  function automatic logic [7:0] exp_sdt(input logic [7:0] sa);
    return mrd('hD000 + (bank() ? 256 : 0) + int'(sa));
  endfunction

  function automatic logic [8:0] exp_scrx(input logic [8:0] p);
    int r;
    logic [7:0] lo, hi;
    r  = int'(p % 256) / 8;
    lo = mrd('hE000 + r);
    hi = mrd('hE020 + r);
    return {hi[0], lo};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) mem['hE000 + i] = 8'h00;
    mem['hE043] = 8'h00;
  endtask

  task automatic cpu_idle();
    bus.CPUMX = 1'b0;
    bus.CPUWR = 1'b0;
  endtask

  task automatic cpu_write(input int a, input logic [7:0] d, input int hold, input bit wobble);
    int b;
    b = a ^ 1;
    bus.CPUMX = 1'b1; bus.CPUWR = 1'b1; bus.CPUAD = a[15:0]; bus.CPUWD = d;
    #1 check("wr_viddv", bus.VIDDV, 0);
    @(posedge clk); #1;
    if (is_hit(a)) mem[a] = d & region_mask(a);
    for (int i = 1; i < hold; i++) begin
      bus.CPUWD = 8'($urandom);
      if (wobble && is_hit(a) && is_hit(b)) bus.CPUAD = b[15:0];
      @(posedge clk); #1;
    end
    cpu_idle();
    @(posedge clk); #1;
  endtask

  task automatic cpu_read(input int a);
    bus.CPUMX = 1'b1; bus.CPUWR = 1'b0; bus.CPUAD = a[15:0];
    #1 check("rd_viddv", bus.VIDDV, is_hit(a));
    @(posedge clk); #1;
    if (is_hit(a)) check("rd_data", bus.VIDRD, mrd(a));
    cpu_idle();
    #1 check("rd_viddv_drop", bus.VIDDV, 0);
    @(posedge clk); #1;
  endtask

  task automatic vid_check(input logic [10:0] va, input logic [7:0] sa, input logic [8:0] p);
    logic [15:0] ev; logic [7:0] es; logic [8:0] ex;
    vad = va; sad = sa; pv = p;
    ev = exp_vdt(va); es = exp_sdt(sa); ex = exp_scrx(p);
    @(posedge clk); #1;
    check("vdt", vdt, ev);
    check("sdt", sdt, es);
    check("scrx", scrx, ex);
    check("spbnk", spbnk, bank());
  endtask

  // Write presented on the same edge the video ports sample: old data first, new data next.
  task automatic write_overlap(input int a, input logic [7:0] d, input logic [10:0] va,
                               input logic [7:0] sa, input logic [8:0] p);
    logic [15:0] ov; logic [7:0] os; logic [8:0] ox;
    vad = va; sad = sa; pv = p;
    ov = exp_vdt(va); os = exp_sdt(sa); ox = exp_scrx(p);
    bus.CPUMX = 1'b1; bus.CPUWR = 1'b1; bus.CPUAD = a[15:0]; bus.CPUWD = d;
    @(posedge clk); #1;
    check("ovl_vdt_old", vdt, ov);
    check("ovl_sdt_old", sdt, os);
    check("ovl_scrx_old", scrx, ox);
    mem[a] = d & region_mask(a);
    check("ovl_spbnk", spbnk, bank());
    cpu_idle();
    @(posedge clk); #1;
    check("ovl_vdt_new", vdt, exp_vdt(va));
    check("ovl_sdt_new", sdt, exp_sdt(sa));
    check("ovl_scrx_new", scrx, exp_scrx(p));
  endtask

  function automatic int rand_addr();
    case ($urandom % 8)
      0: return 'hC000 + int'($urandom % 16);
      1: return 'hC800 + int'($urandom % 16);
      2: return 'hD000 + int'($urandom % 16);
      3: return 'hD100 + int'($urandom % 16);
      4: return 'hE000 + int'($urandom % 32);
      5: return 'hE020 + int'($urandom % 32);
      6: return 'hE043;
      default: begin
        case ($urandom % 4)
          0: return 'hE040 + int'($urandom % 3);
          1: return 'hE044 + int'($urandom % 'hBC);
          2: return 'h8000 + int'($urandom % 'h4000);
          default: return 'hF000 + int'($urandom % 'h1000);
        endcase
      end
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    cpu_idle();
    bus.CPUAD = 16'h0000; bus.CPUWD = 8'h00;
    pv = 9'h000; vad = 11'h000; sad = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_vidrd", bus.VIDRD, 8'h00);
    check("rst_vdt", vdt, 16'h0000);
    check("rst_sdt", sdt, 8'h00);
    check("rst_scrx", scrx, 9'h000);
    check("rst_spbnk", spbnk, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Held write with changing data lands once; read returns it a cycle later.
    cpu_write('hC805, 8'h5A, 4, 1);
    cpu_read('hC805);
    check("c805_literal", bus.VIDRD, 8'h5A);

    cpu_write('hC005, 8'h3C, 1, 0);
    vid_check(11'h005, 8'h00, 9'h000);
    check("vdt_literal", vdt, 16'h3C5A);

    // Same-edge overlap on the tilemap port.
    write_overlap('hC005, 8'h77, 11'h005, 8'h00, 9'h000);

    cpu_write('hD010, 8'h11, 2, 1);
    cpu_write('hD110, 8'h22, 2, 1);
    write_overlap('hE043, 8'h08, 11'h005, 8'h10, 9'h000);
    check("bank1_sdt", sdt, 8'h22);
    check("bank1_spbnk", spbnk, 1'b1);
    cpu_read('hE043);
    write_overlap('hE043, 8'h00, 11'h005, 8'h10, 9'h000);
    check("bank0_sdt", sdt, 8'h11);

    cpu_write('hE003, 8'h80, 1, 0);
    cpu_write('hE023, 8'h01, 3, 1);
    vid_check(11'h000, 8'h00, 9'h018);
    check("scrx_018", scrx, 9'h180);
    vid_check(11'h000, 8'h00, 9'h118);
    check("scrx_118", scrx, 9'h180);
    vid_check(11'h000, 8'h00, 9'h020);
    check("scrx_020", scrx, 9'h000);
    cpu_read('hE023);
    write_overlap('hE000, 8'h44, 11'h005, 8'h10, 9'h005);

    cpu_read('hF600);
    cpu_read('hE044);
    cpu_read('h8000);
    cpu_read('hE041);
    cpu_write('hE044, 8'h07, 2, 0);
    cpu_write('hE042, 8'h0F, 1, 0);
    vid_check(11'h000, 8'h10, 9'h018);

    // Reset during a held write must not commit; RAM survives, scroll and bank clear.
    cpu_write('hD000, 8'hAA, 1, 0);
    cpu_write('hE043, 8'h08, 1, 0);
    pv = 9'h018;
    @(posedge clk); #1;
    rst = 1'b1;
    bus.CPUMX = 1'b1; bus.CPUWR = 1'b1; bus.CPUAD = 16'hD000; bus.CPUWD = 8'hBB;
    #1;
    check("mid_rst_spbnk", spbnk, 1'b0);
    check("mid_rst_scrx", scrx, 9'h000);
    check("mid_rst_vidrd", bus.VIDRD, 8'h00);
    check("mid_rst_vdt", vdt, 16'h0000);
    check("mid_rst_sdt", sdt, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    cpu_idle();
    model_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    cpu_read('hD000);
    cpu_write('hD000, 8'hCC, 3, 0);
    cpu_read('hD000);
    vid_check(11'h000, 8'h00, 9'h018);

    for (int n = 0; n < 400; n++) begin
      case ($urandom % 4)
        0, 1: cpu_write(rand_addr(), 8'($urandom), 1 + int'($urandom % 3), bit'($urandom % 2));
        2: cpu_read(rand_addr());
        default: vid_check(11'($urandom % 16), 8'($urandom % 16), 9'($urandom % 512));
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
